// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, ALU opcode encoding and widths.
package cpu_types_pkg;
   localparam int WORD_W  = 32;
   localparam int SHAMT_W = 5;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'b0000,
      ALU_SRL  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_NOR  = 4'b0111,
      ALU_SLT  = 4'b1010,
      ALU_SLTU = 4'b1011
   } aluop_t;
endpackage

// File: rtl/alu_if.sv
// ALU connection bundle: operands and opcode in, result and flags out.
interface alu_if;
   import cpu_types_pkg::*;

   word_t  a;
   word_t  b;
   aluop_t op;
   word_t  out;
   logic   nf;
   logic   zf;
   logic   vf;
   logic   vf_sticky;

   modport alu (input a, b, op, output out, nf, zf, vf, vf_sticky);
   modport tb  (output a, b, op, input out, nf, zf, vf, vf_sticky);
endinterface

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter for SLL/SRL; right shifts are logical (zero fill).
module alu_shifter
   import cpu_types_pkg::*;
(
   input  word_t              val,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               dir_right,
   output word_t              res
);

   always_comb begin
      res = val;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (shamt[i]) begin
            res = dir_right ? (res >> (2**i)) : (res << (2**i));
         end
      end
   end

endmodule

// File: rtl/alu_core.sv
// 32-bit EX-stage integer ALU with sticky signed-overflow status.
// Define ALU_OUTREG_EN to register out/nf/zf/vf (1-cycle latency).
module alu_core
   import cpu_types_pkg::*;
(
   input logic CLK,
   input logic nRST,
   alu_if.alu  aluif
);

   logic               sub_sel;
   logic               right_sel;
   logic signed [WORD_W-1:0] b_eff;
   logic [WORD_W:0]    sum_full;
   word_t              sum;
   logic               add_vf;
   logic               slt_bit;
   logic               sltu_bit;
   word_t              shift_res;
   word_t              res_p0;
   logic               vf_p0;
   logic               vf_use;
   logic               sticky_q;

   function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   // SUB and both compares share the adder as a + ~b + 1.
   assign sub_sel   = (aluif.op == ALU_SUB) || (aluif.op == ALU_SLT) || (aluif.op == ALU_SLTU);
   assign right_sel = (aluif.op == ALU_SRL);
   assign b_eff     = aluif.b ^ {WORD_W{sub_sel}};
   assign sum_full  = {1'b0, aluif.a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, sub_sel};
   assign sum       = sum_full[WORD_W-1:0];
   assign add_vf    = signed_ovf(aluif.a[WORD_W-1], b_eff[WORD_W-1], sum[WORD_W-1]);
   // Exact compares: sign of the difference corrected by overflow; unsigned uses borrow.
   assign slt_bit   = sum[WORD_W-1] ^ add_vf;
   assign sltu_bit  = ~sum_full[WORD_W];

   alu_shifter u_shifter (
      .val       (aluif.a),
      .shamt     (aluif.b[SHAMT_W-1:0]),
      .dir_right (right_sel),
      .res       (shift_res)
   );

   always_comb begin
      res_p0 = '0;
      vf_p0  = 1'b0;
      case (aluif.op)
         ALU_SLL, ALU_SRL: res_p0 = shift_res;
         ALU_ADD, ALU_SUB: begin
            res_p0 = sum;
            vf_p0  = add_vf;
         end
         ALU_AND:  res_p0 = aluif.a & aluif.b;
         ALU_OR:   res_p0 = aluif.a | aluif.b;
         ALU_XOR:  res_p0 = aluif.a ^ aluif.b;
         ALU_NOR:  res_p0 = ~(aluif.a | aluif.b);
         ALU_SLT:  res_p0 = {{(WORD_W-1){1'b0}}, slt_bit};
         ALU_SLTU: res_p0 = {{(WORD_W-1){1'b0}}, sltu_bit};
         default:  res_p0 = '0;
      endcase
   end

`ifdef ALU_OUTREG_EN
   word_t out_p1;
   logic  nf_p1;
   logic  zf_p1;
   logic  vf_p1;

   // p0 -> p1: registered result and flags
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         out_p1 <= '0;
         nf_p1  <= 1'b0;
         zf_p1  <= 1'b1;
         vf_p1  <= 1'b0;
      end else begin
         out_p1 <= res_p0;
         nf_p1  <= res_p0[WORD_W-1];
         zf_p1  <= (res_p0 == '0);
         vf_p1  <= vf_p0;
      end
   end

   assign aluif.out = out_p1;
   assign aluif.nf  = nf_p1;
   assign aluif.zf  = zf_p1;
   assign aluif.vf  = vf_p1;
   assign vf_use    = vf_p1;
`else
   assign aluif.out = res_p0;
   assign aluif.nf  = res_p0[WORD_W-1];
   assign aluif.zf  = (res_p0 == '0);
   assign aluif.vf  = vf_p0;
   assign vf_use    = vf_p0;
`endif

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_q | vf_use;
      end
   end

   assign aluif.vf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected results queued at drive time, checked at output time.
module tb_alu_core;
   import cpu_types_pkg::*;

`ifdef ALU_OUTREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      string tag;
      word_t out;
      logic  nf;
      logic  zf;
      logic  vf;
      logic  st;
      int    due;
   } exp_t;

   logic  CLK = 1'b0;
   logic  nRST;
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   logic  acc = 1'b0;
   exp_t  q[$];

   alu_if aif ();

   alu_core dut (
      .CLK   (CLK),
      .nRST  (nRST),
      .aluif (aif)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic void model(input aluop_t op, input word_t a, input word_t b,
                                 output word_t o, output logic v);
      longint s;
      o = '0;
      v = 1'b0;
      case (op)
         ALU_SLL:  o = a << b[4:0];
         ALU_SRL:  o = a >> b[4:0];
         ALU_ADD: begin
            s = longint'($signed(a)) + longint'($signed(b));
            o = s[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         ALU_SUB: begin
            s = longint'($signed(a)) - longint'($signed(b));
            o = s[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         ALU_AND:  o = a & b;
         ALU_OR:   o = a | b;
         ALU_XOR:  o = a ^ b;
         ALU_NOR:  o = ~(a | b);
         ALU_SLT:  o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: o = (a < b) ? 32'd1 : 32'd0;
         default:  o = '0;
      endcase
   endfunction

   // Drive one vector for one cycle; rst_v holds nRST low across the next edge.
   task automatic drive(input string tag, input aluop_t op, input word_t a, input word_t b,
                        input logic rst_v);
      exp_t  e;
      word_t o;
      logic  v;
      @(posedge CLK);
      #1;
      aif.op = op;
      aif.a  = a;
      aif.b  = b;
      nRST   = ~rst_v;
      model(op, a, b, o, v);
      e.tag = tag;
      e.due = cyc + LAT;
      if (LAT == 1 && rst_v) begin
         e.out = '0;
         e.nf  = 1'b0;
         e.zf  = 1'b1;
         e.vf  = 1'b0;
         e.st  = 1'b0;
         acc   = 1'b0;
      end else begin
         e.out = o;
         e.nf  = o[31];
         e.zf  = (o == '0);
         e.vf  = v;
         e.st  = acc;
         acc   = rst_v ? 1'b0 : (acc | v);
      end
      q.push_back(e);
   endtask

   always @(negedge CLK) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         chk({e.tag, ".out"}, aif.out, e.out);
         chk({e.tag, ".nf"}, {31'b0, aif.nf}, {31'b0, e.nf});
         chk({e.tag, ".zf"}, {31'b0, aif.zf}, {31'b0, e.zf});
         chk({e.tag, ".vf"}, {31'b0, aif.vf}, {31'b0, e.vf});
         chk({e.tag, ".sticky"}, {31'b0, aif.vf_sticky}, {31'b0, e.st});
      end
   end

   initial begin
      aluop_t ops[10];
      ops = '{ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
              ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};
      nRST   = 1'b0;
      aif.op = ALU_ADD;
      aif.a  = '0;
      aif.b  = '0;
      repeat (2) @(posedge CLK);

      drive("add_zero",   ALU_ADD,  32'd0, 32'd0, 1'b0);
      drive("add_neg",    ALU_ADD,  -32'sd300, 32'd200, 1'b0);
      drive("sub_pos",    ALU_SUB,  32'd1024, -32'sd10, 1'b0);
      drive("sll",        ALU_SLL,  32'd1024, 32'd2, 1'b0);
      drive("srl",        ALU_SRL,  32'd1024, 32'd2, 1'b0);
      drive("srl_msb",    ALU_SRL,  32'h8000_0000, 32'd31, 1'b0);
      drive("sll_amt",    ALU_SLL,  32'h0000_0003, 32'hFFFF_FFE4, 1'b0);
      drive("sltu_1",     ALU_SLTU, 32'd1024, 32'd2333, 1'b0);
      drive("sltu_0",     ALU_SLTU, 32'd29, 32'd2, 1'b0);
      drive("slt_0",      ALU_SLT,  -32'sd1024, -32'sd2333, 1'b0);
      drive("slt_1",      ALU_SLT,  -32'sd1024, 32'd233, 1'b0);
      drive("slt_wrap",   ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
      drive("sltu_wrap",  ALU_SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
      drive("or",         ALU_OR,   32'd3, 32'd4, 1'b0);
      drive("and",        ALU_AND,  32'd3, 32'd2, 1'b0);
      drive("xor",        ALU_XOR,  32'd2, 32'd1, 1'b0);
      drive("nor",        ALU_NOR,  32'd0, 32'd1, 1'b0);
      drive("undef_f",    aluop_t'(4'b1111), 32'hDEAD_BEEF, 32'd5, 1'b0);
      drive("undef_8",    aluop_t'(4'b1000), 32'h8000_0001, 32'd1, 1'b0);
      drive("sub_ovf",    ALU_SUB,  32'h8000_0000, 32'd100, 1'b0);
      drive("add_ovf",    ALU_ADD,  32'h7FFF_FFFF, 32'd1, 1'b0);
      drive("add_after",  ALU_ADD,  32'd1, 32'd1, 1'b0);
      drive("hold",       ALU_ADD,  32'd1, 32'd1, 1'b0);
      drive("rst_ovf",    ALU_ADD,  32'h7FFF_FFFF, 32'd1, 1'b1);
      drive("post_rst",   ALU_ADD,  32'd0, 32'd0, 1'b0);
      drive("post_rst2",  ALU_SUB,  32'd5, 32'd3, 1'b0);

      for (int i = 0; i < 40; i++) begin
         word_t ra, rb;
         ra = (i % 3 == 0) ? ($urandom & 32'h8000_00FF) : $urandom;
         rb = (i % 4 == 0) ? ($urandom & 32'h8000_00FF) : $urandom;
         drive("rand", ops[$urandom_range(0, 9)], ra, rb, 1'b0);
      end

      drive("tail_rst",   ALU_ADD,  32'd0, 32'd0, 1'b1);
      drive("tail",       ALU_OR,   32'd0, 32'd0, 1'b0);

      repeat (LAT + 3) @(posedge CLK);
      @(negedge CLK);
      #1;
      chk("drain", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=%0d expected=%0d", cyc, 0);
      $fatal(1, "bench timeout");
   end

endmodule
